// File: rtl/truth_table_sequencer.sv
// Sweeps all eight {a,b,c} vectors through a 3-input combinational block,
// captures y per vector, and scores the captured truth table against a golden table.
//
// state  | meaning
// IDLE   | outputs parked at 0, waiting for start
// APPLY  | vector driven, settle counter running
// SAMPLE | last cycle of the vector window, y captured on exit
// DONE   | one-cycle completion pulse, pass result visible
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter logic [7:0]  GOLDEN_DEFAULT = 8'h21
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       use_default_i,
  input  logic [7:0] golden_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] table_out_o,
  output logic [3:0] err_count_o,
  output logic [2:0] first_fail_o,
  output logic       fail_valid_o
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  // Legal SETTLE_CYCLES is 1..15, so the terminal count fits the 4-bit counter.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] vec_q;
  logic [3:0] cnt_q;
  logic [7:0] golden_q;
  logic [2:0] abc_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] table_q;
  logic [3:0] err_count_q;
  logic [2:0] first_fail_q;
  logic       fail_valid_q;

  logic       mismatch_d;
  logic [3:0] err_count_d;

  assign mismatch_d  = (y_i != golden_q[vec_q]);
  assign err_count_d = err_count_q + {3'b000, mismatch_d};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      vec_q        <= 3'd0;
      cnt_q        <= 4'd0;
      golden_q     <= 8'h00;
      abc_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      table_q      <= 8'h00;
      err_count_q  <= 4'd0;
      first_fail_q <= 3'd0;
      fail_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            golden_q     <= use_default_i ? GOLDEN_DEFAULT : golden_i;
            table_q      <= 8'h00;
            err_count_q  <= 4'd0;
            first_fail_q <= 3'd0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            vec_q        <= 3'd0;
            cnt_q        <= 4'd0;
            abc_q        <= 3'd0;
            busy_q       <= 1'b1;
            state_q      <= APPLY;
          end
        end
        APPLY: begin
          if (abort_i) begin
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          // An abort landing on the sample edge wins and the capture is dropped.
          if (abort_i) begin
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            table_q[vec_q] <= y_i;
            err_count_q    <= err_count_d;
            if (mismatch_d && !fail_valid_q) begin
              first_fail_q <= vec_q;
              fail_valid_q <= 1'b1;
            end
            if (vec_q == 3'd7) begin
              abc_q   <= 3'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == 4'd0);
              state_q <= DONE;
            end else begin
              vec_q   <= vec_q + 3'd1;
              abc_q   <= vec_q + 3'd1;
              cnt_q   <= 4'd0;
              state_q <= APPLY;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {a_o, b_o, c_o} = abc_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign table_out_o     = table_q;
  assign err_count_o     = err_count_q;
  assign first_fail_o    = first_fail_q;
  assign fail_valid_o    = fail_valid_q;

endmodule
